mesi_isc_cpu_port: RTL and testbench
====================================

Name: mesi_isc_cpu_port

Overview:
- Per-CPU bus agent sitting directly upstream of the mesi_isc coherence controller; one instance per CPU (0..3).
- Converts a simple CPU request (RD/WR + address) into the controller's two-phase main-bus protocol: broadcast, wait for enable, ack, then access.
- Independently answers coherence-bus snoops so the controller never deadlocks while this port has a request outstanding.

Parameters:
- ADDR_WIDTH, 32, address width (matches controller).
- MBUS_CMD_WIDTH, 3, main-bus command width.
- CBUS_CMD_WIDTH, 3, coherence-bus command width.
- SNOOP_LAT, 2, cycles from snoop detection to cbus_ack_o (1..15).
- TIMEOUT, 255, max cycles in any wait state before timeout_o (8-bit counter).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req_valid_i  in  1  CPU request valid
- cpu_req_wr_i  in  1  1=write, 0=read
- cpu_req_addr_i  in  ADDR_WIDTH  request address
- cpu_req_ready_o  out  1  port idle, accepts request
- cpu_done_o  out  1  one-cycle pulse, access complete
- mbus_cmd_o  out  MBUS_CMD_WIDTH  main-bus command to controller
- mbus_addr_o  out  ADDR_WIDTH  main-bus address to controller
- mbus_ack_i  in  1  main-bus acknowledge from controller
- cbus_cmd_i  in  CBUS_CMD_WIDTH  coherence command from controller
- cbus_addr_i  in  ADDR_WIDTH  coherence address (shared by all CPUs)
- cbus_ack_o  out  1  coherence acknowledge to controller
- snoop_valid_o  out  1  one-cycle pulse to cache on snoop accept
- snoop_wr_o  out  1  1=WR_SNOOP (invalidate), 0=RD_SNOOP (downgrade)
- snoop_addr_o  out  ADDR_WIDTH  snooped address
- proto_err_o  out  1  sticky: EN_x address/type mismatch
- timeout_o  out  1  sticky: wait exceeded TIMEOUT

Behaviour:
- Encodings: MBUS NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4. CBUS NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- Reset: all outputs 0; mbus_cmd_o=NOP; mbus_addr_o=0; FSM=IDLE; counters 0. Reset mid-transaction aborts immediately with no done pulse.
- Main FSM:
  - IDLE: cpu_req_ready_o=1. On valid, latch wr/addr and go to BROAD.
  - BROAD: mbus_cmd_o = WR_BROAD or RD_BROAD, mbus_addr_o = latched address. Command is held until mbus_ack_i=1 is sampled. Next cycle: cmd=NOP, go to WAIT_EN.
  - WAIT_EN: wait for cbus_cmd_i = EN_WR or EN_RD. If the type differs from the latched op, or cbus_addr_i differs from the latched address, set proto_err_o; proceed regardless. Go to EN_ACK.
  - EN_ACK: cbus_ack_o=1 for exactly one cycle, then go to ACCESS.
  - ACCESS: mbus_cmd_o = WR or RD, same address, held until mbus_ack_i is sampled. Then go to DONE.
  - DONE: cpu_done_o=1 for one cycle, then IDLE. A new request can be accepted the cycle after DONE, giving 1 idle bubble.
- mbus_cmd_o is registered and is never NOP while in BROAD or ACCESS. A mbus_ack_i outside BROAD/ACCESS is ignored.
- Snoop engine, running concurrently with the main FSM:
  - Arms on cbus_cmd_i in {WR_SNOOP, RD_SNOOP} while armed. Pulses snoop_valid_o, snoop_wr_o and snoop_addr_o in the detection cycle.
  - Counts SNOOP_LAT cycles, then asserts cbus_ack_o for one cycle.
  - Re-arms only after cbus_cmd_i == NOP is seen, so each command gets exactly one ack.
- EN_ACK and the snoop ack never coincide, because the bus carries one command at a time. cbus_ack_o is the OR of the two sources.
- Watchdog: counts cycles in BROAD, WAIT_EN and ACCESS, clearing on each state change. On reaching TIMEOUT it sets timeout_o (sticky until reset); the FSM keeps waiting.
- Simultaneous cases:
  - cpu_req_valid_i while a snoop is in progress: request accepted normally.
  - Snoop arriving in WAIT_EN: serviced; FSM stays in WAIT_EN.

Decomposition:
- Shared package mesi_isc_pkg holds the MBUS/CBUS command enums (values above), the main FSM state typedef, and the default widths.
- One natural sub-module: mesi_isc_snoop_resp (snoop detect, latency counter, ack, re-arm). Main FSM and watchdog stay in the top module.

Test Plan:
- Write: req wr=1 addr=0x1. Expect mbus_cmd_o=3 until ack. Then cbus_cmd_i=3 addr=0x1 -> cbus_ack_o one cycle later. Then mbus_cmd_o=1 until ack -> cpu_done_o pulse; proto_err_o=0.
- Read: req wr=0 addr=0xABCD; controller acks after 5 cycles. mbus_cmd_o=4 is held all 5 cycles. EN_RD path completes with mbus_cmd_o=2 -> single done pulse.
- Snoop during WAIT_EN: cbus_cmd_i=1 addr=0x40, SNOOP_LAT=2. Expect snoop_valid_o/snoop_wr_o=1 in the same cycle, ack 2 cycles later, exactly one ack while the command is held 4 cycles; FSM stays in WAIT_EN.
- Mismatch: pending write to 0x1, controller sends EN_RD addr 0x2 -> proto_err_o=1 sticky; ack still issued; transaction completes.
- Timeout: TIMEOUT=8, mbus_ack_i never asserted in BROAD -> timeout_o=1 on the 8th wait cycle; mbus_cmd_o stays 3.
- Reset mid-ACCESS: assert rst asynchronously -> mbus_cmd_o=0, cbus_ack_o=0, cpu_req_ready_o=0 while reset is held; after release cpu_req_ready_o=1; no cpu_done_o.

Source files
------------

// File: rtl/mesi_isc_pkg.sv
// Shared encodings, FSM states and default widths for the mesi_isc CPU port.
package mesi_isc_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_MBUS_CMD_WIDTH = 3;
  localparam int DEF_CBUS_CMD_WIDTH = 3;

  typedef enum logic [2:0] {
    MBUS_NOP      = 3'd0,
    MBUS_WR       = 3'd1,
    MBUS_RD       = 3'd2,
    MBUS_WR_BROAD = 3'd3,
    MBUS_RD_BROAD = 3'd4
  } mbus_cmd_e;

  typedef enum logic [2:0] {
    CBUS_NOP      = 3'd0,
    CBUS_WR_SNOOP = 3'd1,
    CBUS_RD_SNOOP = 3'd2,
    CBUS_EN_WR    = 3'd3,
    CBUS_EN_RD    = 3'd4
  } cbus_cmd_e;

  typedef logic [2:0] port_state_t;

  localparam port_state_t ST_IDLE    = 3'd0;
  localparam port_state_t ST_BROAD   = 3'd1;
  localparam port_state_t ST_WAIT_EN = 3'd2;
  localparam port_state_t ST_EN_ACK  = 3'd3;
  localparam port_state_t ST_ACCESS  = 3'd4;
  localparam port_state_t ST_DONE    = 3'd5;

  // States where the port is stalled on the controller and the watchdog runs.
  function automatic logic is_wait_state(port_state_t s);
    return (s == ST_BROAD) || (s == ST_WAIT_EN) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/mesi_isc_snoop_resp.sv
// Coherence-bus snoop responder: detects a snoop, forwards it to the cache,
// acks after SNOOP_LAT cycles and waits for a NOP before accepting another.
module mesi_isc_snoop_resp
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int CBUS_CMD_WIDTH = DEF_CBUS_CMD_WIDTH,
  parameter int SNOOP_LAT      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      snoop_ack_o,
  output logic                      snoop_valid_o,
  output logic                      snoop_wr_o,
  output logic [ADDR_WIDTH-1:0]     snoop_addr_o
);

  localparam logic [CBUS_CMD_WIDTH-1:0] C_NOP      = CBUS_CMD_WIDTH'(CBUS_NOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_WR_SNOOP = CBUS_CMD_WIDTH'(CBUS_WR_SNOOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_RD_SNOOP = CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
  localparam logic [3:0]                LAT        = 4'(SNOOP_LAT);

  logic       armed_q;
  logic       nop_seen_q;
  logic [3:0] lat_cnt_q;
  logic       detect;

  assign detect        = armed_q && ((cbus_cmd_i == C_WR_SNOOP) || (cbus_cmd_i == C_RD_SNOOP));
  assign snoop_valid_o = detect;
  assign snoop_wr_o    = detect && (cbus_cmd_i == C_WR_SNOOP);
  assign snoop_addr_o  = detect ? cbus_addr_i : '0;
  assign snoop_ack_o   = (lat_cnt_q == 4'd1);

  // A NOP seen before the ack has gone out is remembered so re-arming is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      nop_seen_q <= 1'b0;
      lat_cnt_q  <= 4'd0;
    end else if (detect) begin
      armed_q    <= 1'b0;
      nop_seen_q <= 1'b0;
      lat_cnt_q  <= LAT;
    end else begin
      if (lat_cnt_q != 4'd0)
        lat_cnt_q <= lat_cnt_q - 4'd1;
      if (!armed_q && (cbus_cmd_i == C_NOP))
        nop_seen_q <= 1'b1;
      if (!armed_q && (lat_cnt_q == 4'd0) && (nop_seen_q || (cbus_cmd_i == C_NOP))) begin
        armed_q    <= 1'b1;
        nop_seen_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mesi_isc_cpu_port.sv
// Per-CPU agent in front of the mesi_isc controller: runs the two-phase
// broadcast/enable/access handshake and answers snoops concurrently.
module mesi_isc_cpu_port
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int MBUS_CMD_WIDTH = DEF_MBUS_CMD_WIDTH,
  parameter int CBUS_CMD_WIDTH = DEF_CBUS_CMD_WIDTH,
  parameter int SNOOP_LAT      = 2,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid_i,
  input  logic                      cpu_req_wr_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_req_addr_i,
  output logic                      cpu_req_ready_o,
  output logic                      cpu_done_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic                      snoop_valid_o,
  output logic                      snoop_wr_o,
  output logic [ADDR_WIDTH-1:0]     snoop_addr_o,
  output logic                      proto_err_o,
  output logic                      timeout_o
);

  localparam logic [MBUS_CMD_WIDTH-1:0] M_NOP      = MBUS_CMD_WIDTH'(MBUS_NOP);
  localparam logic [MBUS_CMD_WIDTH-1:0] M_WR       = MBUS_CMD_WIDTH'(MBUS_WR);
  localparam logic [MBUS_CMD_WIDTH-1:0] M_RD       = MBUS_CMD_WIDTH'(MBUS_RD);
  localparam logic [MBUS_CMD_WIDTH-1:0] M_WR_BROAD = MBUS_CMD_WIDTH'(MBUS_WR_BROAD);
  localparam logic [MBUS_CMD_WIDTH-1:0] M_RD_BROAD = MBUS_CMD_WIDTH'(MBUS_RD_BROAD);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_WR    = CBUS_CMD_WIDTH'(CBUS_EN_WR);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_RD    = CBUS_CMD_WIDTH'(CBUS_EN_RD);
  localparam logic [7:0]                WD_LIMIT   = 8'(TIMEOUT);

  port_state_t               state_q;
  port_state_t               state_d;
  logic                      op_wr_q;
  logic                      op_wr_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q;
  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_d;
  logic [7:0]                wd_cnt_q;
  logic [7:0]                wd_cnt_d;
  logic                      ready_en_q;
  logic                      proto_err_q;
  logic                      timeout_q;
  logic                      accept;
  logic                      en_seen;
  logic                      en_mismatch;
  logic                      snoop_ack;

  // ready_en_q keeps the port from advertising readiness while reset is held.
  assign cpu_req_ready_o = ready_en_q && (state_q == ST_IDLE);
  assign accept          = cpu_req_valid_i && cpu_req_ready_o;
  assign op_wr_d         = accept ? cpu_req_wr_i : op_wr_q;
  assign en_seen         = (cbus_cmd_i == C_EN_WR) || (cbus_cmd_i == C_EN_RD);
  assign en_mismatch     = ((cbus_cmd_i == C_EN_WR) != op_wr_q) || (cbus_addr_i != addr_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_BROAD;
      ST_BROAD:   if (mbus_ack_i) state_d = ST_WAIT_EN;
      ST_WAIT_EN: if (en_seen) state_d = ST_EN_ACK;
      ST_EN_ACK:  state_d = ST_ACCESS;
      ST_ACCESS:  if (mbus_ack_i) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The command is decoded from the next state so it is registered yet aligned with it.
  always_comb begin
    mbus_cmd_d = M_NOP;
    case (state_d)
      ST_BROAD:  mbus_cmd_d = op_wr_d ? M_WR_BROAD : M_RD_BROAD;
      ST_ACCESS: mbus_cmd_d = op_wr_d ? M_WR : M_RD;
      default:   mbus_cmd_d = M_NOP;
    endcase
  end

  // Watchdog value is the number of cycles spent so far in the current wait state.
  always_comb begin
    wd_cnt_d = 8'd0;
    if (is_wait_state(state_d)) begin
      if (state_d != state_q)
        wd_cnt_d = 8'd1;
      else if (wd_cnt_q != 8'hFF)
        wd_cnt_d = wd_cnt_q + 8'd1;
      else
        wd_cnt_d = wd_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      mbus_cmd_q  <= M_NOP;
      wd_cnt_q    <= 8'd0;
      ready_en_q  <= 1'b0;
      proto_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mbus_cmd_q <= mbus_cmd_d;
      wd_cnt_q   <= wd_cnt_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        op_wr_q <= cpu_req_wr_i;
        addr_q  <= cpu_req_addr_i;
      end
      if ((state_q == ST_WAIT_EN) && en_seen && en_mismatch)
        proto_err_q <= 1'b1;
      if ((WD_LIMIT != 8'd0) && (wd_cnt_d == WD_LIMIT))
        timeout_q <= 1'b1;
    end
  end

  mesi_isc_snoop_resp #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CBUS_CMD_WIDTH (CBUS_CMD_WIDTH),
    .SNOOP_LAT      (SNOOP_LAT)
  ) u_snoop (
    .clk           (clk),
    .rst           (rst),
    .cbus_cmd_i    (cbus_cmd_i),
    .cbus_addr_i   (cbus_addr_i),
    .snoop_ack_o   (snoop_ack),
    .snoop_valid_o (snoop_valid_o),
    .snoop_wr_o    (snoop_wr_o),
    .snoop_addr_o  (snoop_addr_o)
  );

  assign mbus_cmd_o  = mbus_cmd_q;
  assign mbus_addr_o = addr_q;
  assign cpu_done_o  = (state_q == ST_DONE);
  assign cbus_ack_o  = (state_q == ST_EN_ACK) || snoop_ack;
  assign proto_err_o = proto_err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mesi_isc_cpu_port.sv
// Randomized bench for mesi_isc_cpu_port with a transaction-level controller model.
module tb_mesi_isc_cpu_port;

  localparam int AW  = 32;
  localparam int LAT = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req_valid_i = 1'b0;
  logic          cpu_req_wr_i = 1'b0;
  logic [AW-1:0] cpu_req_addr_i = '0;
  logic          cpu_req_ready_o;
  logic          cpu_done_o;
  logic [2:0]    mbus_cmd_o;
  logic [AW-1:0] mbus_addr_o;
  logic          mbus_ack_i = 1'b0;
  logic [2:0]    cbus_cmd_i = 3'd0;
  logic [AW-1:0] cbus_addr_i = '0;
  logic          cbus_ack_o;
  logic          snoop_valid_o;
  logic          snoop_wr_o;
  logic [AW-1:0] snoop_addr_o;
  logic          proto_err_o;
  logic          timeout_o;

  int   errors = 0;
  int   checks = 0;
  logic exp_proto = 1'b0;

  always #5 clk = ~clk;

  mesi_isc_cpu_port #(
    .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3), .SNOOP_LAT(LAT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_wr_i(cpu_req_wr_i), .cpu_req_addr_i(cpu_req_addr_i),
    .cpu_req_ready_o(cpu_req_ready_o), .cpu_done_o(cpu_done_o),
    .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
    .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o),
    .snoop_valid_o(snoop_valid_o), .snoop_wr_o(snoop_wr_o), .snoop_addr_o(snoop_addr_o),
    .proto_err_o(proto_err_o), .timeout_o(timeout_o)
  );

  // Controller model: one full handshake, expected outputs derived from the protocol rules.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input int bd, input int ed,
                         input int ad, input logic en_wr, input logic [AW-1:0] en_addr,
                         input int snoop_len, input logic snoop_wr, input logic [AW-1:0] snoop_addr);
    int         acks;
    logic [2:0] exp_broad;
    logic [2:0] exp_acc;
    exp_broad = wr ? 3'd3 : 3'd4;
    exp_acc   = wr ? 3'd1 : 3'd2;
    @(negedge clk);
    cpu_req_valid_i = 1'b1; cpu_req_wr_i = wr; cpu_req_addr_i = addr; #1;
    checks++; if (cpu_req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL req_ready: got %b expected 1", cpu_req_ready_o); end
    checks++; if (cpu_done_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_done: got %b expected 0", cpu_done_o); end
    for (int i = 0; i <= bd; i++) begin
      @(negedge clk);
      cpu_req_valid_i = 1'b0; cpu_req_addr_i = $urandom; mbus_ack_i = (i == bd); #1;
      checks++; if (mbus_cmd_o !== exp_broad) begin errors++; $display("[TB] FAIL broad_cmd: got %0d expected %0d", mbus_cmd_o, exp_broad); end
      checks++; if (mbus_addr_o !== addr) begin errors++; $display("[TB] FAIL broad_addr: got %0h expected %0h", mbus_addr_o, addr); end
      checks++; if (cpu_req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready: got %b expected 0", cpu_req_ready_o); end
    end
    acks = 0;
    for (int s = 0; s < snoop_len + 1 && snoop_len > 0; s++) begin
      @(negedge clk);
      mbus_ack_i  = $urandom_range(0, 1);
      cbus_cmd_i  = (s < snoop_len) ? (snoop_wr ? 3'd1 : 3'd2) : 3'd0;
      cbus_addr_i = snoop_addr; #1;
      if (cbus_ack_o === 1'b1) acks++;
      checks++; if (snoop_valid_o !== (s == 0)) begin errors++; $display("[TB] FAIL wait_snoop_valid: cycle %0d got %b expected %b", s, snoop_valid_o, s == 0); end
      checks++; if (cbus_ack_o !== (s == LAT)) begin errors++; $display("[TB] FAIL wait_snoop_ack: cycle %0d got %b expected %b", s, cbus_ack_o, s == LAT); end
      checks++; if (mbus_cmd_o !== 3'd0) begin errors++; $display("[TB] FAIL wait_snoop_cmd: got %0d expected 0", mbus_cmd_o); end
      if (s == 0) begin
        checks++; if (snoop_wr_o !== snoop_wr) begin errors++; $display("[TB] FAIL wait_snoop_wr: got %b expected %b", snoop_wr_o, snoop_wr); end
        checks++; if (snoop_addr_o !== snoop_addr) begin errors++; $display("[TB] FAIL wait_snoop_addr: got %0h expected %0h", snoop_addr_o, snoop_addr); end
      end
    end
    if (snoop_len > 0) begin
      checks++; if (acks != 1) begin errors++; $display("[TB] FAIL wait_snoop_ack_count: got %0d expected 1", acks); end
    end
    for (int j = 0; j <= ed; j++) begin
      @(negedge clk);
      mbus_ack_i  = $urandom_range(0, 1);
      cbus_cmd_i  = (j == ed) ? (en_wr ? 3'd3 : 3'd4) : 3'd0;
      cbus_addr_i = (j == ed) ? en_addr : $urandom; #1;
      checks++; if (cbus_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL wait_en_ack: got %b expected 0", cbus_ack_o); end
      checks++; if (mbus_cmd_o !== 3'd0) begin errors++; $display("[TB] FAIL wait_en_cmd: got %0d expected 0", mbus_cmd_o); end
    end
    @(negedge clk);
    mbus_ack_i = $urandom_range(0, 1); #1;
    exp_proto = exp_proto | (en_wr != wr) | (en_addr != addr);
    checks++; if (cbus_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL en_ack: got %b expected 1", cbus_ack_o); end
    checks++; if (proto_err_o !== exp_proto) begin errors++; $display("[TB] FAIL proto_err: got %b expected %b", proto_err_o, exp_proto); end
    for (int k = 0; k <= ad; k++) begin
      @(negedge clk);
      cbus_cmd_i = 3'd0; mbus_ack_i = (k == ad); #1;
      checks++; if (mbus_cmd_o !== exp_acc) begin errors++; $display("[TB] FAIL access_cmd: got %0d expected %0d", mbus_cmd_o, exp_acc); end
      checks++; if (mbus_addr_o !== addr) begin errors++; $display("[TB] FAIL access_addr: got %0h expected %0h", mbus_addr_o, addr); end
      checks++; if (cbus_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL access_ack: got %b expected 0", cbus_ack_o); end
      checks++; if (cpu_done_o !== 1'b0) begin errors++; $display("[TB] FAIL early_done: got %b expected 0", cpu_done_o); end
    end
    @(negedge clk);
    mbus_ack_i = $urandom_range(0, 1); #1;
    checks++; if (cpu_done_o !== 1'b1) begin errors++; $display("[TB] FAIL done_pulse: got %b expected 1", cpu_done_o); end
    checks++; if (cpu_req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL done_ready: got %b expected 0", cpu_req_ready_o); end
    checks++; if (mbus_cmd_o !== 3'd0) begin errors++; $display("[TB] FAIL done_cmd: got %0d expected 0", mbus_cmd_o); end
    checks++; if (proto_err_o !== exp_proto) begin errors++; $display("[TB] FAIL done_proto: got %b expected %b", proto_err_o, exp_proto); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL done_timeout: got %b expected 0", timeout_o); end
  endtask

  task automatic test_reset();
    rst = 1'b1; exp_proto = 1'b0;
    @(negedge clk); #1;
    checks++; if (cpu_req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", cpu_req_ready_o); end
    checks++; if (mbus_cmd_o !== 3'd0) begin errors++; $display("[TB] FAIL rst_cmd: got %0d expected 0", mbus_cmd_o); end
    checks++; if (mbus_addr_o !== '0) begin errors++; $display("[TB] FAIL rst_addr: got %0h expected 0", mbus_addr_o); end
    checks++; if ({cpu_done_o, cbus_ack_o, snoop_valid_o, proto_err_o, timeout_o} !== 5'd0) begin
      errors++; $display("[TB] FAIL rst_flags: got %b expected 00000", {cpu_done_o, cbus_ack_o, snoop_valid_o, proto_err_o, timeout_o});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cpu_req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_ready: got %b expected 1", cpu_req_ready_o); end
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'h1, 2, 1, 1, 1'b1, 32'h1, 0, 1'b0, '0);
  endtask

  task automatic test_read();
    run_txn(1'b0, 32'hABCD, 4, 2, 2, 1'b0, 32'hABCD, 0, 1'b0, '0);
  endtask

  task automatic test_snoop_wait();
    run_txn(1'b1, 32'h100, 1, 0, 0, 1'b1, 32'h100, 4, 1'b1, 32'h40);
    run_txn(1'b0, 32'h2000, 0, 1, 1, 1'b0, 32'h2000, 3, 1'b0, 32'h80);
  endtask

  task automatic test_snoop_idle();
    int         len;
    int         acks;
    logic       swr;
    logic [AW-1:0] saddr;
    @(negedge clk);
    cbus_cmd_i = 3'd0;
    for (int rep = 0; rep < 3; rep++) begin
      len = $urandom_range(3, 5); swr = $urandom_range(0, 1); saddr = $urandom; acks = 0;
      for (int s = 0; s <= len; s++) begin
        @(negedge clk);
        cbus_cmd_i = (s < len) ? (swr ? 3'd1 : 3'd2) : 3'd0; cbus_addr_i = saddr; #1;
        if (cbus_ack_o === 1'b1) acks++;
        checks++; if (snoop_valid_o !== (s == 0)) begin errors++; $display("[TB] FAIL idle_snoop_valid: cycle %0d got %b expected %b", s, snoop_valid_o, s == 0); end
        checks++; if (cbus_ack_o !== (s == LAT)) begin errors++; $display("[TB] FAIL idle_snoop_ack: cycle %0d got %b expected %b", s, cbus_ack_o, s == LAT); end
        checks++; if (cpu_req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL idle_snoop_ready: got %b expected 1", cpu_req_ready_o); end
        if (s == 0) begin
          checks++; if (snoop_wr_o !== swr) begin errors++; $display("[TB] FAIL idle_snoop_wr: got %b expected %b", snoop_wr_o, swr); end
          checks++; if (snoop_addr_o !== saddr) begin errors++; $display("[TB] FAIL idle_snoop_addr: got %0h expected %0h", snoop_addr_o, saddr); end
        end
      end
      checks++; if (acks != 1) begin errors++; $display("[TB] FAIL idle_snoop_ack_count: got %0d expected 1", acks); end
    end
  endtask

  task automatic test_random();
    logic          wr;
    logic [AW-1:0] addr;
    int            slen;
    for (int n = 0; n < 12; n++) begin
      wr = $urandom_range(0, 1); addr = $urandom;
      slen = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 4) : 0;
      run_txn(wr, addr, $urandom_range(0, 5), (slen > 0) ? $urandom_range(0, 1) : $urandom_range(0, 5),
              $urandom_range(0, 4), wr, addr, slen, $urandom_range(0, 1), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++)
      run_txn(n[0], 32'h1000 + n, 0, 0, 0, n[0], 32'h1000 + n, 0, 1'b0, '0);
  endtask

  task automatic test_mismatch();
    run_txn(1'b1, 32'h1, 1, 0, 1, 1'b0, 32'h2, 0, 1'b0, '0);
    run_txn(1'b0, 32'h30, 0, 1, 0, 1'b0, 32'h30, 0, 1'b0, '0);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    mbus_ack_i = 1'b0; cbus_cmd_i = 3'd0;
    cpu_req_valid_i = 1'b1; cpu_req_wr_i = 1'b1; cpu_req_addr_i = 32'h55; #1;
    for (int k = 1; k <= TMO + 2; k++) begin
      @(negedge clk);
      cpu_req_valid_i = 1'b0; #1;
      checks++; if (timeout_o !== (k >= TMO)) begin errors++; $display("[TB] FAIL timeout_flag: cycle %0d got %b expected %b", k, timeout_o, k >= TMO); end
      checks++; if (mbus_cmd_o !== 3'd3) begin errors++; $display("[TB] FAIL timeout_cmd: cycle %0d got %0d expected 3", k, mbus_cmd_o); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic wr;
    wr = $urandom_range(0, 1);
    @(negedge clk); rst = 1'b1; mbus_ack_i = 1'b0; cbus_cmd_i = 3'd0; exp_proto = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    cpu_req_valid_i = 1'b1; cpu_req_wr_i = wr; cpu_req_addr_i = 32'h77;
    @(negedge clk); cpu_req_valid_i = 1'b0; mbus_ack_i = 1'b1;
    @(negedge clk); mbus_ack_i = 1'b0; cbus_cmd_i = wr ? 3'd3 : 3'd4; cbus_addr_i = 32'h77;
    @(negedge clk);
    @(negedge clk); cbus_cmd_i = 3'd0; #1;
    checks++; if (mbus_cmd_o !== (wr ? 3'd1 : 3'd2)) begin errors++; $display("[TB] FAIL pre_rst_access: got %0d expected %0d", mbus_cmd_o, wr ? 1 : 2); end
    #2; rst = 1'b1; #1;
    for (int r = 0; r < 2; r++) begin
      checks++; if (mbus_cmd_o !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_cmd: got %0d expected 0", mbus_cmd_o); end
      checks++; if (cbus_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ack: got %b expected 0", cbus_ack_o); end
      checks++; if (cpu_req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b expected 0", cpu_req_ready_o); end
      checks++; if (cpu_done_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_done: got %b expected 0", cpu_done_o); end
      @(negedge clk); #1;
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (cpu_done_o !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_done: got %b expected 0", cpu_done_o); end
      checks++; if (cpu_req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_ready2: got %b expected 1", cpu_req_ready_o); end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_snoop_wait();
    test_snoop_idle();
    test_random();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
